reg_file_sb: RTL and testbench

Parametrised register file with a scoreboard, the successor to the fixed 32×32 F-extension file. It serves both the integer (register 0 hardwired) and FP pipelines. Width, depth and read-port count are configurable. Write-first bypass is kept, and two features are new:
- a per-register pending (scoreboard) bit for long-latency producers, such as the FP divider;
- a sequenced clear engine that zeroes the storage after reset or on request, so the array itself needs no reset.

---
 rtl/reg_file_sb_pkg.sv | 18 +
 rtl/reg_file_sb_if.sv | 34 +++
 rtl/reg_file_sb_scoreboard.sv | 50 +++++
 rtl/reg_file_sb.sv | 120 ++++++++++++
 tb/tb_reg_file_sb.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared types and defaults for the scoreboarded register file.
// Holds the clear/run state encoding, default widths and the port-slice helper.
package reg_file_sb_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } rf_state_t;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;

   // Low bit of port k inside a flattened multi-port bus of w-bit lanes.
   function automatic int port_lsb(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: read ports, write port, issue port, clear request and status.
// ready: high while the file is usable; requests presented while ready is low are ignored.
interface reg_file_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREAD  = 3
);
   import reg_file_sb_pkg::*;

   logic [NREAD*ADDR_W-1:0] ra;
   logic [NREAD*DATA_W-1:0] rd;
   logic [NREAD-1:0]        busy;
   logic [ADDR_W-1:0]       dbg_ra;
   logic [DATA_W-1:0]       dbg_rd;
   logic                    we;
   logic [ADDR_W-1:0]       wa;
   logic [DATA_W-1:0]       wd;
   logic                    iss_we;
   logic [ADDR_W-1:0]       iss_wa;
   logic                    clr_req;
   logic                    ready;
   rf_state_t               dbg_state;

   modport master (
      output ra, dbg_ra, we, wa, wd, iss_we, iss_wa, clr_req,
      input  rd, busy, dbg_rd, ready, dbg_state
   );

   modport slave (
      input  ra, dbg_ra, we, wa, wd, iss_we, iss_wa, clr_req,
      output rd, busy, dbg_rd, ready, dbg_state
   );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register pending bits for long-latency producers, plus the busy lookup for each read port.
// An issue on the same register as a landing write wins, so the newer producer stays tracked.
module rf_scoreboard
   import reg_file_sb_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NREAD    = 3,
   parameter bit ZERO_REG = 1'b0
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    run,
   input  logic                    clr_all,
   input  logic                    set_en,
   input  logic [ADDR_W-1:0]       set_addr,
   input  logic                    clr_en,
   input  logic [ADDR_W-1:0]       clr_addr,
   input  logic                    byp_we,
   input  logic [ADDR_W-1:0]       byp_wa,
   input  logic [NREAD*ADDR_W-1:0] ra,
   output logic [NREAD-1:0]        busy
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DEPTH-1:0] pending_q, pending_d;

   always_comb begin
      pending_d = pending_q;
      if (clr_all) begin
         pending_d = '0;
      end else begin
         if (clr_en) pending_d[clr_addr] = 1'b0;
         if (set_en) pending_d[set_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) pending_q <= '0;
      else       pending_q <= pending_d;
   end

   for (genvar k = 0; k < NREAD; k++) begin : g_busy
      logic [ADDR_W-1:0] ra_k;
      assign ra_k = ra[port_lsb(k, ADDR_W) +: ADDR_W];
      // A write landing this cycle releases the consumer immediately.
      assign busy[k] = run && !(ZERO_REG && (ra_k == '0)) && pending_q[ra_k]
                       && !(byp_we && (byp_wa == ra_k));
   end

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with write-first bypass, pending scoreboard and a clear sweep.
// The storage has no reset; the CLEAR state zeroes one entry per cycle before the file goes ready.
module reg_file_sb
   import reg_file_sb_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NREAD    = 3,
   parameter bit ZERO_REG = 1'b0
) (
   input  logic          clk,
   input  logic          rstn,
   reg_file_sb_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   rf_state_t         state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              ready_q, ready_d;

   logic              run;
   logic              clr_all;
   logic              wr_ok;
   logic              iss_ok;
   logic              rf_wen;
   logic [ADDR_W-1:0] rf_wa;
   logic [DATA_W-1:0] rf_wd;

   logic [DATA_W-1:0] rf_q [DEPTH];

   assign run = (state_q == RUN);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      clr_all = 1'b0;
      wr_ok   = 1'b0;
      iss_ok  = 1'b0;
      rf_wen  = 1'b0;
      rf_wa   = idx_q;
      rf_wd   = '0;
      case (state_q)
         CLEAR: begin
            rf_wen = 1'b1;
            idx_d  = idx_q + 1'b1;
            if (&idx_q) state_d = RUN;
         end
         RUN: begin
            // A clear request wins over any write or issue sampled on the same edge.
            if (bus.clr_req) begin
               state_d = CLEAR;
               idx_d   = '0;
               clr_all = 1'b1;
            end else begin
               wr_ok  = bus.we && !(ZERO_REG && (bus.wa == '0));
               iss_ok = bus.iss_we && !(ZERO_REG && (bus.iss_wa == '0));
               rf_wen = wr_ok;
               rf_wa  = bus.wa;
               rf_wd  = bus.wd;
            end
         end
         default: state_d = CLEAR;
      endcase
      ready_d = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= CLEAR;
         idx_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ready_q <= ready_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rf_wen) rf_q[rf_wa] <= rf_wd;
   end

   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra_k;
      logic [DATA_W-1:0] rd_k;
      assign ra_k = bus.ra[port_lsb(k, ADDR_W) +: ADDR_W];
      always_comb begin
         rd_k = '0;
         if (run && !(ZERO_REG && (ra_k == '0))) begin
            if (bus.we && (bus.wa == ra_k)) rd_k = bus.wd;
            else                            rd_k = rf_q[ra_k];
         end
      end
      assign bus.rd[port_lsb(k, DATA_W) +: DATA_W] = rd_k;
   end

   rf_scoreboard #(
      .ADDR_W   (ADDR_W),
      .NREAD    (NREAD),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk      (clk),
      .rstn     (rstn),
      .run      (run),
      .clr_all  (clr_all),
      .set_en   (iss_ok),
      .set_addr (bus.iss_wa),
      .clr_en   (wr_ok),
      .clr_addr (bus.wa),
      .byp_we   (bus.we),
      .byp_wa   (bus.wa),
      .ra       (bus.ra),
      .busy     (bus.busy)
   );

   assign bus.dbg_rd    = rf_q[bus.dbg_ra];
   assign bus.ready     = ready_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomised and directed bench for reg_file_sb against a per-register behavioural model.
// The model tracks data, pending flags and the remaining clear-sweep length from the documented rules.
module tb_reg_file_sb;
   import reg_file_sb_pkg::*;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NR    = 3;
   localparam int DEPTH = 32;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) bus ();

   reg_file_sb #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .NREAD    (NR),
      .ZERO_REG (1'b1)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   // Reference model
   logic [DW-1:0] m_rf [DEPTH];
   bit            m_known [DEPTH];
   bit            m_pend [DEPTH];
   bit            m_ready;
   int            m_left;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ready = 1'b0;
      m_left  = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
   endtask

   task automatic model_edge();
      if (m_ready) begin
         if (bus.clr_req) begin
            m_ready = 1'b0;
            m_left  = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
         end else begin
            if (bus.we && bus.wa != 0) begin
               m_rf[bus.wa]    = bus.wd;
               m_known[bus.wa] = 1'b1;
               m_pend[bus.wa]  = 1'b0;
            end
            if (bus.iss_we && bus.iss_wa != 0) m_pend[bus.iss_wa] = 1'b1;
         end
      end else begin
         m_rf[DEPTH - m_left]    = '0;
         m_known[DEPTH - m_left] = 1'b1;
         m_left--;
         if (m_left == 0) m_ready = 1'b1;
      end
   endtask

   task automatic check_outputs();
      for (int k = 0; k < NR; k++) begin
         logic [AW-1:0] a;
         logic [DW-1:0] exp_rd;
         logic          exp_busy;
         bit            known;
         a        = bus.ra[k*AW +: AW];
         exp_rd   = '0;
         exp_busy = 1'b0;
         known    = 1'b1;
         if (m_ready && a != 0) begin
            if (bus.we && bus.wa == a) begin
               exp_rd = bus.wd;
            end else begin
               exp_rd   = m_rf[a];
               exp_busy = m_pend[a];
               known    = m_known[a];
            end
         end
         if (known) check_eq($sformatf("rd%0d", k), 64'(bus.rd[k*DW +: DW]), 64'(exp_rd));
         check_eq($sformatf("busy%0d", k), 64'(bus.busy[k]), 64'(exp_busy));
      end
      check_eq("ready", 64'(bus.ready), 64'(m_ready));
      if (m_known[bus.dbg_ra]) check_eq("dbg_rd", 64'(bus.dbg_rd), 64'(m_rf[bus.dbg_ra]));
   endtask

   // Call at the negedge: checks the cycle, advances through the edge, updates the model.
   task automatic finish_cycle();
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic step();
      @(negedge clk);
      finish_cycle();
   endtask

   task automatic idle();
      bus.we      = 1'b0;
      bus.wa      = '0;
      bus.wd      = '0;
      bus.iss_we  = 1'b0;
      bus.iss_wa  = '0;
      bus.clr_req = 1'b0;
      bus.ra      = '0;
      bus.dbg_ra  = '0;
   endtask

   task automatic set_ra(input int k, input logic [AW-1:0] a);
      bus.ra[k*AW +: AW] = a;
   endtask

   task automatic rand_inputs(input int clr_pct);
      bus.we     = 1'($urandom_range(0, 1));
      bus.wa     = AW'($urandom_range(0, DEPTH-1));
      bus.wd     = $urandom;
      bus.iss_we = ($urandom_range(0, 3) == 0);
      bus.iss_wa = ($urandom_range(0, 3) == 0) ? bus.wa : AW'($urandom_range(0, DEPTH-1));
      for (int k = 0; k < NR; k++)
         set_ra(k, ($urandom_range(0, 2) == 0) ? bus.wa : AW'($urandom_range(0, DEPTH-1)));
      bus.dbg_ra  = AW'($urandom_range(0, DEPTH-1));
      bus.clr_req = ($urandom_range(0, 99) < clr_pct);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      model_reset();
      #1;
      check_eq("rst_ready", 64'(bus.ready), 64'(0));
      check_eq("rst_state", 64'(bus.dbg_state), 64'(CLEAR));
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!bus.ready && n < 200) begin
         step();
         n++;
      end
   endtask

   initial begin
      int n;
      logic [DW-1:0] v;
      logic [DW-1:0] old4;

      idle();
      for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
      do_reset();

      // First sweep with random traffic that must be ignored
      for (int i = 0; i < DEPTH; i++) begin
         rand_inputs(20);
         step();
      end
      idle();
      check_eq("first_sweep_ready", 64'(bus.ready), 64'(1));

      // Preload every register with nonzero data
      for (int a = 0; a < DEPTH; a++) begin
         bus.we = 1'b1;
         bus.wa = AW'(a);
         bus.wd = $urandom | 32'h1;
         step();
      end
      idle();

      // Reset mid-sweep, then a full sweep
      do_reset();
      for (int i = 0; i < 10; i++) begin
         rand_inputs(10);
         step();
      end
      do_reset();
      idle();
      for (int k = 0; k < NR; k++) set_ra(k, AW'(k + 1));
      wait_ready(n);
      check_eq("sweep_len", 64'(n), 64'(DEPTH));
      for (int a = 0; a < DEPTH; a++) begin
         bus.dbg_ra = AW'(a);
         @(negedge clk);
         check_eq("dbg_zero", 64'(bus.dbg_rd), 64'(0));
         finish_cycle();
      end

      // Bypass
      idle();
      bus.we = 1'b1; bus.wa = 7; bus.wd = 32'h1111_1111;
      step();
      bus.wd = 32'h3F80_0000; set_ra(0, 7); bus.dbg_ra = 7;
      @(negedge clk);
      check_eq("bypass_rd0", 64'(bus.rd[0 +: DW]), 64'(32'h3F80_0000));
      check_eq("bypass_dbg_old", 64'(bus.dbg_rd), 64'(32'h1111_1111));
      finish_cycle();
      idle(); bus.dbg_ra = 7;
      @(negedge clk);
      check_eq("bypass_dbg_new", 64'(bus.dbg_rd), 64'(32'h3F80_0000));
      finish_cycle();

      // Scoreboard set, then release by a write
      idle();
      bus.iss_we = 1'b1; bus.iss_wa = 5;
      step();
      idle(); set_ra(1, 5);
      @(negedge clk);
      check_eq("sb_busy_set", 64'(bus.busy[1]), 64'(1));
      finish_cycle();
      bus.we = 1'b1; bus.wa = 5; bus.wd = 32'h4000_0000;
      @(negedge clk);
      check_eq("sb_busy_release", 64'(bus.busy[1]), 64'(0));
      check_eq("sb_rd1", 64'(bus.rd[DW +: DW]), 64'(32'h4000_0000));
      finish_cycle();
      idle(); set_ra(1, 5);
      @(negedge clk);
      check_eq("sb_busy_after", 64'(bus.busy[1]), 64'(0));
      finish_cycle();

      // Set and clear collide on register 9
      v = $urandom;
      bus.we = 1'b1; bus.wa = 9; bus.wd = v; bus.iss_we = 1'b1; bus.iss_wa = 9;
      step();
      idle(); set_ra(2, 9); bus.dbg_ra = 9;
      @(negedge clk);
      check_eq("collide_busy", 64'(bus.busy[2]), 64'(1));
      check_eq("collide_data", 64'(bus.dbg_rd), 64'(v));
      finish_cycle();

      // Register 0 is hardwired
      idle();
      bus.we = 1'b1; bus.wa = 0; bus.wd = 32'hDEAD_BEEF; bus.iss_we = 1'b1; bus.iss_wa = 0;
      @(negedge clk);
      check_eq("zero_rd_same", 64'(bus.rd[0 +: DW]), 64'(0));
      finish_cycle();
      idle();
      @(negedge clk);
      check_eq("zero_rd", 64'(bus.rd[0 +: DW]), 64'(0));
      check_eq("zero_busy", 64'(bus.busy[0]), 64'(0));
      finish_cycle();

      // Clear mid-run with pending registers and a colliding write
      old4 = 32'hA5A5_A5A5;
      bus.we = 1'b1; bus.wa = 4; bus.wd = old4; step();
      bus.wa = 3; bus.wd = 32'h0000_0333; step();
      bus.wa = 12; bus.wd = 32'h0000_0CCC; step();
      idle(); bus.iss_we = 1'b1; bus.iss_wa = 3; step();
      bus.iss_wa = 12; step();
      idle(); bus.clr_req = 1'b1; bus.we = 1'b1; bus.wa = 4; bus.wd = 32'h1234_5678;
      step();
      idle(); bus.dbg_ra = 4;
      @(negedge clk);
      check_eq("clr_ready_low", 64'(bus.ready), 64'(0));
      check_eq("clr_we_dropped", 64'(bus.dbg_rd), 64'(old4));
      finish_cycle();
      wait_ready(n);
      check_eq("clr_sweep_len", 64'(n + 1), 64'(DEPTH));
      for (int a = 0; a < DEPTH; a++) begin
         for (int k = 0; k < NR; k++) set_ra(k, AW'(a));
         @(negedge clk);
         check_eq("clr_rd0", 64'(bus.rd[0 +: DW]), 64'(0));
         check_eq("clr_busy", 64'(bus.busy), 64'(0));
         finish_cycle();
      end

      // Random traffic including occasional clears and held clear requests
      for (int i = 0; i < 1500; i++) begin
         rand_inputs(3);
         step();
      end
      idle();
      bus.clr_req = 1'b1;
      for (int i = 0; i < 3 * DEPTH; i++) step();
      idle();
      for (int i = 0; i < DEPTH + 2; i++) step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
